neuro_op_sequencer: RTL and testbench
=====================================

// Module: neuro_op_sequencer
// PURPOSE
//  Host-side initiator for the control-register block. Accepts one layer-operation command per
//  valid/ready handshake and writes offset, dest, numOps and cacheRouter over the register bus.
//  Optionally reads the four registers back and checks them, then pulses beginOp.
//  Tracks readyForNextOp to completion and reports status; sits between host/DMA and register file.
// PARAMETERS
//  OFFSET_ADDR     16'h8000  address of offset register
//  DEST_ADDR       16'h8001  address of destination register
//  NUMOPS_ADDR     16'h8002  address of numOps register
//  ROUTER_ADDR     16'h8003  address of cacheRouter register (7 valid bits)
//  VERIFY_EN       1         1 = read back and compare after writes; 0 = skip RD states
//  TIMEOUT_CYCLES  1024      max cycles from beginOp to op completion (>=2)
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  cmdValid        in   1   command valid
//  cmdReady        out  1   high only in IDLE
//  cmdOffset       in   16  offset register value
//  cmdDest         in   16  destination register value
//  cmdNumOps       in   16  numOps register value
//  cmdRouter       in   7   {writeReverse,actFuncSel[1:0],cacheSel[1:0],weightNOTIndex,paramNOTLayer}
//  busWE           out  1   register-bus write enable (to WE)
//  busAddr         out  16  register-bus address (to inAddr)
//  busWData        out  16  register-bus write data (to inData)
//  busRData        in   16  register-bus read data (from outData, combinational on busAddr)
//  beginOp         out  1   one-cycle start pulse to the operation FSM
//  readyForNextOp  in   1   level from FSM: 1 = idle, 0 = operation running
//  busy            out  1   high in every state except IDLE
//  done            out  1   one-cycle pulse when command retires (success or error)
//  errVerify       out  1   sticky: readback mismatch on last command
//  errTimeout      out  1   sticky: completion timeout on last command
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busWE=0, busAddr=0, busWData=0, beginOp=0, busy=0,
//   done=0, errVerify=0, errTimeout=0, cmdReady=1 after reset release; latched cmd = 0.
//  All outputs registered (Moore) except cmdReady = (state==IDLE).
//  IDLE: on cmdValid&&cmdReady latch the four fields, clear both err flags, go WR_OFF.
//  WR_OFF,WR_DST,WR_NUM,WR_RTR: one cycle each, busWE=1, busAddr=<reg>_ADDR, busWData=field;
//   router written as {9'd0,cmdRouter}. Next: RD_OFF if VERIFY_EN else START.
//  RD_OFF..RD_RTR: one cycle each, busWE=0, busAddr=<reg>_ADDR; compare busRData at end of cycle
//   vs latched value (router vs {9'd0,cmdRouter}). First mismatch: set errVerify, go DONE,
//   no beginOp issued. All match after RD_RTR: go START.
//  START: beginOp=1 for exactly one cycle; timeout counter cleared; go WAIT_ACK.
//  WAIT_ACK: wait for readyForNextOp==0; then WAIT_FIN.
//  WAIT_FIN: wait for readyForNextOp==1; then DONE.
//  Timeout: 16-bit counter increments each cycle in WAIT_ACK/WAIT_FIN; on reaching
//   TIMEOUT_CYCLES-1 without exit, set errTimeout and go DONE.
//  Exit condition and timeout in the same cycle: exit wins, no error.
//  DONE: done=1 one cycle, busWE=0, busAddr=0; go IDLE. Err flags hold until next accept.
//  Best case latency accept->done: 12 cycles with VERIFY_EN=1, 8 with VERIFY_EN=0, given the FSM
//   drops ready one cycle after beginOp and raises it the following cycle.
//  cmdValid ignored outside IDLE; fields latched only at accept, so later changes have no effect.
//  busWE never high outside WR_* states; beginOp never high outside START.
//  Reset mid-operation: immediate return to IDLE, bus/beginOp deasserted; no done pulse.
// TESTING
//  1 Cmd off=0x0010,dst=0x0200,num=0x0040,rtr=0x5A, model regfile, FSM ack 1cyc/fin 3cyc ->
//    4 writes at 8000..8003 in order, 4 reads match, 1 beginOp, done at cycle 14, errs 0.
//  2 Regfile model corrupts dest readback (0x0201) -> errVerify=1, done pulses, beginOp never asserted.
//  3 TIMEOUT_CYCLES=16, FSM never drops ready -> errTimeout=1, done 16 cycles after beginOp.
//  4 VERIFY_EN=0, back-to-back cmdValid held high -> 2nd accepted only after done; no RD states.
//  5 Deassert rst_n during WAIT_FIN -> busy=0, beginOp=0, no done; next cmd runs cleanly.
//  6 Ready rises in the exact timeout cycle -> errTimeout=0, done=1.

Source files
------------

// File: rtl/neuro_op_sequencer.sv
// neuro_op_sequencer
//   Host-side initiator for the control-register block. Takes one layer-op
//   command per valid/ready handshake, writes offset/dest/numOps/cacheRouter
//   over the register bus, optionally reads them back to check, pulses
//   beginOp, then follows readyForNextOp to completion and reports status.
// Ports
//   clk, rst_n                 clock / async active-low reset
//   cmdValid/cmdReady          command handshake (ready only in IDLE)
//   cmdOffset/Dest/NumOps      16-bit register values
//   cmdRouter                  7-bit cacheRouter value
//   busWE/busAddr/busWData     register-bus write side (registered)
//   busRData                   register-bus read data, combinational on busAddr
//   beginOp                    one-cycle start pulse to operation FSM
//   readyForNextOp             1 = op FSM idle, 0 = running
//   busy/done                  status; done pulses once per retired command
//   errVerify/errTimeout       sticky error flags for the last command
module neuro_op_sequencer #(
  parameter logic [15:0] OFFSET_ADDR    = 16'h8000,
  parameter logic [15:0] DEST_ADDR      = 16'h8001,
  parameter logic [15:0] NUMOPS_ADDR    = 16'h8002,
  parameter logic [15:0] ROUTER_ADDR    = 16'h8003,
  parameter bit          VERIFY_EN      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [15:0] cmdOffset,
  input  logic [15:0] cmdDest,
  input  logic [15:0] cmdNumOps,
  input  logic [6:0]  cmdRouter,
  output logic        busWE,
  output logic [15:0] busAddr,
  output logic [15:0] busWData,
  input  logic [15:0] busRData,
  output logic        beginOp,
  input  logic        readyForNextOp,
  output logic        busy,
  output logic        done,
  output logic        errVerify,
  output logic        errTimeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_OFF, S_WR_DST, S_WR_NUM, S_WR_RTR,
    S_RD_OFF, S_RD_DST, S_RD_NUM, S_RD_RTR,
    S_START, S_WAIT_ACK, S_WAIT_FIN, S_DONE
  } state_e;

  // The counter starts at 0 in the first wait cycle; timing out when it
  // would step onto TIMEOUT_CYCLES-1 gives DONE exactly TIMEOUT_CYCLES
  // cycles after beginOp.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 2);

  state_e      state_q, state_d;
  logic [15:0] off_q, off_d, dst_q, dst_d, num_q, num_d;
  logic [6:0]  rtr_q, rtr_d;
  logic [15:0] tmo_q, tmo_d;
  logic        ev_q, ev_d, et_q, et_d;
  logic        we_q, we_d, beg_q, beg_d, done_q, done_d, busy_q, busy_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;

  // Next-state, command latch, readback check and timeout.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    dst_d   = dst_q;
    num_d   = num_q;
    rtr_d   = rtr_q;
    tmo_d   = tmo_q;
    ev_d    = ev_q;
    et_d    = et_q;
    case (state_q)
      S_IDLE: if (cmdValid) begin
        off_d   = cmdOffset;
        dst_d   = cmdDest;
        num_d   = cmdNumOps;
        rtr_d   = cmdRouter;
        ev_d    = 1'b0;
        et_d    = 1'b0;
        state_d = S_WR_OFF;
      end
      S_WR_OFF: state_d = S_WR_DST;
      S_WR_DST: state_d = S_WR_NUM;
      S_WR_NUM: state_d = S_WR_RTR;
      S_WR_RTR: state_d = VERIFY_EN ? S_RD_OFF : S_START;
      S_RD_OFF: if (busRData != off_q) begin
        ev_d = 1'b1; state_d = S_DONE;
      end else state_d = S_RD_DST;
      S_RD_DST: if (busRData != dst_q) begin
        ev_d = 1'b1; state_d = S_DONE;
      end else state_d = S_RD_NUM;
      S_RD_NUM: if (busRData != num_q) begin
        ev_d = 1'b1; state_d = S_DONE;
      end else state_d = S_RD_RTR;
      S_RD_RTR: if (busRData != {9'd0, rtr_q}) begin
        ev_d = 1'b1; state_d = S_DONE;
      end else state_d = S_START;
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_ACK;
      end
      // Counter runs across both wait states, so the budget covers the
      // whole operation. A legal exit takes priority over the timeout.
      S_WAIT_ACK: begin
        tmo_d = tmo_q + 16'd1;
        if (!readyForNextOp) state_d = S_WAIT_FIN;
        else if (tmo_q == TMO_LAST) begin
          et_d = 1'b1; state_d = S_DONE;
        end
      end
      S_WAIT_FIN: begin
        tmo_d = tmo_q + 16'd1;
        if (readyForNextOp) state_d = S_DONE;
        else if (tmo_q == TMO_LAST) begin
          et_d = 1'b1; state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they are registered and
  // line up with the state they belong to.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    beg_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_WR_OFF: begin we_d = 1'b1; addr_d = OFFSET_ADDR; wdata_d = off_d; end
      S_WR_DST: begin we_d = 1'b1; addr_d = DEST_ADDR;   wdata_d = dst_d; end
      S_WR_NUM: begin we_d = 1'b1; addr_d = NUMOPS_ADDR; wdata_d = num_d; end
      S_WR_RTR: begin we_d = 1'b1; addr_d = ROUTER_ADDR; wdata_d = {9'd0, rtr_d}; end
      S_RD_OFF: addr_d = OFFSET_ADDR;
      S_RD_DST: addr_d = DEST_ADDR;
      S_RD_NUM: addr_d = NUMOPS_ADDR;
      S_RD_RTR: addr_d = ROUTER_ADDR;
      S_START:  beg_d  = 1'b1;
      S_DONE:   done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      dst_q   <= '0;
      num_q   <= '0;
      rtr_q   <= '0;
      tmo_q   <= '0;
      ev_q    <= 1'b0;
      et_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      dst_q   <= dst_d;
      num_q   <= num_d;
      rtr_q   <= rtr_d;
      tmo_q   <= tmo_d;
      ev_q    <= ev_d;
      et_q    <= et_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beg_q   <= beg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign cmdReady   = (state_q == S_IDLE);
  assign busWE      = we_q;
  assign busAddr    = addr_q;
  assign busWData   = wdata_q;
  assign beginOp    = beg_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign errVerify  = ev_q;
  assign errTimeout = et_q;

endmodule

// File: tb/tb_neuro_op_sequencer.sv
// Directed bench for neuro_op_sequencer: main instance with readback and a
// 16-cycle timeout, second instance without readback for back-to-back runs.
module tb_neuro_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmdValid = 1'b0, nv_cmdValid = 1'b0;
  logic [15:0] cmdOffset = '0, cmdDest = '0, cmdNumOps = '0;
  logic [6:0]  cmdRouter = '0;
  logic        rdy = 1'b1;

  logic        cmdReady, busWE, beginOp, busy, done, errVerify, errTimeout;
  logic [15:0] busAddr, busWData, busRData;
  logic        nv_cmdReady, nv_busWE, nv_beginOp, nv_busy, nv_done, nv_errVerify, nv_errTimeout;
  logic [15:0] nv_busAddr, nv_busWData;
  logic [15:0] nv_rdata = 16'h0;

  neuro_op_sequencer #(.VERIFY_EN(1'b1), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOffset(cmdOffset), .cmdDest(cmdDest), .cmdNumOps(cmdNumOps), .cmdRouter(cmdRouter),
    .busWE(busWE), .busAddr(busAddr), .busWData(busWData), .busRData(busRData),
    .beginOp(beginOp), .readyForNextOp(rdy), .busy(busy), .done(done),
    .errVerify(errVerify), .errTimeout(errTimeout));

  neuro_op_sequencer #(.VERIFY_EN(1'b0), .TIMEOUT_CYCLES(16)) u_nv (
    .clk(clk), .rst_n(rst_n), .cmdValid(nv_cmdValid), .cmdReady(nv_cmdReady),
    .cmdOffset(cmdOffset), .cmdDest(cmdDest), .cmdNumOps(cmdNumOps), .cmdRouter(cmdRouter),
    .busWE(nv_busWE), .busAddr(nv_busAddr), .busWData(nv_busWData), .busRData(nv_rdata),
    .beginOp(nv_beginOp), .readyForNextOp(rdy), .busy(nv_busy), .done(nv_done),
    .errVerify(nv_errVerify), .errTimeout(nv_errTimeout));

  // Register file model, optional corruption of the dest readback.
  logic [15:0] regf [4];
  logic        corrupt_dst = 1'b0;
  always @(posedge clk)
    if (busWE && busAddr[15:2] == 14'h2000) regf[busAddr[1:0]] <= busWData;
  always_comb begin
    busRData = 16'h0;
    case (busAddr)
      16'h8000: busRData = regf[0];
      16'h8001: busRData = regf[1] ^ {15'd0, corrupt_dst};
      16'h8002: busRData = regf[2];
      16'h8003: busRData = regf[3];
      default:  busRData = 16'h0;
    endcase
  end

  // Operation FSM model: ready drops the cycle after beginOp, stays low
  // fin_len cycles, then rises. fsm_en=0 never acknowledges.
  bit fsm_en = 1'b1;
  int fin_len = 1;
  always begin
    @(posedge clk); #1;
    if (fsm_en && (beginOp || nv_beginOp)) begin
      @(posedge clk); #1;
      rdy = 1'b0;
      repeat (fin_len) @(posedge clk);
      #1 rdy = 1'b1;
    end
  end

  int errors = 0, checks = 0;
  int n_wr, n_rd, n_beg, beg_cyc, done_cyc;
  logic ev_at, et_at;
  logic [15:0] wr_addr [8];
  logic [15:0] wr_data [8];

  // Issues one command on the selected instance and traces it until done
  // (or max_cyc cycles). Cycle 1 is the first cycle after the accept edge.
  task automatic run_cmd(input bit nv, input int max_cyc);
    logic we, bg, dn;
    logic [15:0] ad, wd;
    n_wr = 0; n_rd = 0; n_beg = 0; beg_cyc = -1; done_cyc = -1; ev_at = 0; et_at = 0;
    if (nv) nv_cmdValid = 1'b1; else cmdValid = 1'b1;
    @(posedge clk); #1;
    cmdValid = 1'b0; nv_cmdValid = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      we = nv ? nv_busWE : busWE;
      ad = nv ? nv_busAddr : busAddr;
      wd = nv ? nv_busWData : busWData;
      bg = nv ? nv_beginOp : beginOp;
      dn = nv ? nv_done : done;
      if (we) begin
        if (n_wr < 8) begin wr_addr[n_wr] = ad; wr_data[n_wr] = wd; end
        n_wr++;
      end else if (ad != 16'h0) n_rd++;
      if (bg) begin n_beg++; beg_cyc = c; end
      if (dn) begin
        done_cyc = c;
        ev_at = nv ? nv_errVerify : errVerify;
        et_at = nv ? nv_errTimeout : errTimeout;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++; if ({busWE, beginOp, busy, done, errVerify, errTimeout, cmdReady} !== 7'b0000001) begin errors++; $display("FAIL reset_flags got=%b exp=%b", {busWE, beginOp, busy, done, errVerify, errTimeout, cmdReady}, 7'b0000001); end
    checks++; if ({busAddr, busWData} !== 32'h0) begin errors++; $display("FAIL reset_bus got=%h exp=%h", {busAddr, busWData}, 32'h0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({cmdReady, busy, nv_cmdReady, nv_busy} !== 4'b1010) begin errors++; $display("FAIL reset_release got=%b exp=%b", {cmdReady, busy, nv_cmdReady, nv_busy}, 4'b1010); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h0010; exp_d[1] = 16'h0200; exp_d[2] = 16'h0040; exp_d[3] = 16'h005A;
    cmdOffset = 16'h0010; cmdDest = 16'h0200; cmdNumOps = 16'h0040; cmdRouter = 7'h5A;
    fsm_en = 1'b1; fin_len = 3;
    run_cmd(1'b0, 40);
    checks++; if (n_wr !== 4) begin errors++; $display("FAIL basic_nwr got=%0d exp=%0d", n_wr, 4); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_addr[i] !== 16'h8000 + 16'(i)) begin errors++; $display("FAIL basic_waddr%0d got=%h exp=%h", i, wr_addr[i], 16'h8000 + 16'(i)); end
      checks++; if (wr_data[i] !== exp_d[i]) begin errors++; $display("FAIL basic_wdata%0d got=%h exp=%h", i, wr_data[i], exp_d[i]); end
    end
    checks++; if (n_rd !== 4) begin errors++; $display("FAIL basic_nrd got=%0d exp=%0d", n_rd, 4); end
    checks++; if (n_beg !== 1 || beg_cyc !== 9) begin errors++; $display("FAIL basic_begin got=%0d@%0d exp=1@9", n_beg, beg_cyc); end
    checks++; if (done_cyc !== 14) begin errors++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc, 14); end
    checks++; if ({ev_at, et_at} !== 2'b00) begin errors++; $display("FAIL basic_errs got=%b exp=%b", {ev_at, et_at}, 2'b00); end
    checks++; if (regf[3] !== 16'h005A) begin errors++; $display("FAIL basic_regf_rtr got=%h exp=%h", regf[3], 16'h005A); end
    @(posedge clk); #1;
    checks++; if ({done, busy, cmdReady} !== 3'b001) begin errors++; $display("FAIL basic_after got=%b exp=%b", {done, busy, cmdReady}, 3'b001); end
  endtask

  task automatic test_verify_err();
    corrupt_dst = 1'b1; fin_len = 1;
    run_cmd(1'b0, 40);
    checks++; if (done_cyc !== 7) begin errors++; $display("FAIL verr_done_cyc got=%0d exp=%0d", done_cyc, 7); end
    checks++; if ({ev_at, et_at} !== 2'b10) begin errors++; $display("FAIL verr_errs got=%b exp=%b", {ev_at, et_at}, 2'b10); end
    checks++; if (n_beg !== 0) begin errors++; $display("FAIL verr_begin got=%0d exp=%0d", n_beg, 0); end
    checks++; if (n_rd !== 2) begin errors++; $display("FAIL verr_nrd got=%0d exp=%0d", n_rd, 2); end
    @(posedge clk); #1;
    checks++; if ({errVerify, done} !== 2'b10) begin errors++; $display("FAIL verr_sticky got=%b exp=%b", {errVerify, done}, 2'b10); end
    corrupt_dst = 1'b0;
  endtask

  task automatic test_timeout();
    cmdOffset = 16'h1234; cmdDest = 16'h5678; cmdNumOps = 16'h0009; cmdRouter = 7'h7F;
    fsm_en = 1'b0;
    run_cmd(1'b0, 60);
    checks++; if (beg_cyc !== 9) begin errors++; $display("FAIL tmo_begin_cyc got=%0d exp=%0d", beg_cyc, 9); end
    checks++; if (done_cyc !== 25) begin errors++; $display("FAIL tmo_done_cyc got=%0d exp=%0d", done_cyc, 25); end
    checks++; if ({ev_at, et_at} !== 2'b01) begin errors++; $display("FAIL tmo_errs got=%b exp=%b", {ev_at, et_at}, 2'b01); end
    @(posedge clk); #1;
    checks++; if ({errTimeout, done} !== 2'b10) begin errors++; $display("FAIL tmo_sticky got=%b exp=%b", {errTimeout, done}, 2'b10); end
    fsm_en = 1'b1;
  endtask

  task automatic test_timeout_edge();
    fin_len = 14;
    run_cmd(1'b0, 60);
    checks++; if (done_cyc !== 25) begin errors++; $display("FAIL tedge_done_cyc got=%0d exp=%0d", done_cyc, 25); end
    checks++; if ({ev_at, et_at} !== 2'b00) begin errors++; $display("FAIL tedge_errs got=%b exp=%b", {ev_at, et_at}, 2'b00); end
    fin_len = 1;
  endtask

  task automatic test_back_to_back();
    logic        lw [1:20];
    logic        lr [1:20];
    logic        ld [1:20];
    logic [15:0] la [1:20];
    logic [15:0] lv [1:20];
    logic [15:0] exp_a [4];
    int n_rdy, n_rdc;
    exp_a[0] = 16'h0A0A; exp_a[1] = 16'h0B0B; exp_a[2] = 16'h0C0C; exp_a[3] = 16'h0011;
    cmdOffset = 16'h0A0A; cmdDest = 16'h0B0B; cmdNumOps = 16'h0C0C; cmdRouter = 7'h11;
    fin_len = 1;
    nv_cmdValid = 1'b1;
    @(posedge clk); #1;
    cmdOffset = 16'h1111; cmdDest = 16'h2222; cmdNumOps = 16'h3333; cmdRouter = 7'h22;
    for (int c = 1; c <= 20; c++) begin
      lw[c] = nv_busWE; la[c] = nv_busAddr; lv[c] = nv_busWData;
      lr[c] = nv_cmdReady; ld[c] = nv_done;
      if (c == 10) nv_cmdValid = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({lw[i+1], la[i+1], lv[i+1]} !== {1'b1, 16'h8000 + 16'(i), exp_a[i]}) begin errors++; $display("FAIL b2b_wr%0d got=%b/%h/%h exp=1/%h/%h", i, lw[i+1], la[i+1], lv[i+1], 16'h8000 + 16'(i), exp_a[i]); end
    end
    n_rdy = 0; n_rdc = 0;
    for (int c = 1; c <= 8; c++) begin
      if (lr[c]) n_rdy++;
      if (!lw[c] && la[c] != 16'h0) n_rdc++;
    end
    checks++; if (n_rdy !== 0) begin errors++; $display("FAIL b2b_ready_busy got=%0d exp=%0d", n_rdy, 0); end
    checks++; if (n_rdc !== 0) begin errors++; $display("FAIL b2b_no_reads got=%0d exp=%0d", n_rdc, 0); end
    checks++; if ({ld[7], ld[8], ld[9]} !== 3'b010) begin errors++; $display("FAIL b2b_done1 got=%b exp=%b", {ld[7], ld[8], ld[9]}, 3'b010); end
    checks++; if (lr[9] !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got=%b exp=%b", lr[9], 1'b1); end
    checks++; if ({lw[10], la[10], lv[10]} !== {1'b1, 16'h8000, 16'h1111}) begin errors++; $display("FAIL b2b_wr_b0 got=%b/%h/%h exp=1/8000/1111", lw[10], la[10], lv[10]); end
    checks++; if ({la[11], lv[11]} !== {16'h8001, 16'h2222}) begin errors++; $display("FAIL b2b_wr_b1 got=%h/%h exp=8001/2222", la[11], lv[11]); end
    checks++; if ({ld[16], ld[17]} !== 2'b01) begin errors++; $display("FAIL b2b_done2 got=%b exp=%b", {ld[16], ld[17]}, 2'b01); end
  endtask

  task automatic test_reset_mid();
    int n_done;
    cmdOffset = 16'h0777; cmdDest = 16'h0888; cmdNumOps = 16'h0999; cmdRouter = 7'h03;
    fin_len = 10;
    cmdValid = 1'b1;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got=%b exp=%b", busy, 1'b1); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, beginOp, busWE, done, cmdReady} !== 5'b00001) begin errors++; $display("FAIL rmid_in_reset got=%b exp=%b", {busy, beginOp, busWE, done, cmdReady}, 5'b00001); end
    checks++; if (busAddr !== 16'h0) begin errors++; $display("FAIL rmid_addr got=%h exp=%h", busAddr, 16'h0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=%0d", n_done, 0); end
    fin_len = 1;
    run_cmd(1'b0, 40);
    checks++; if (done_cyc !== 12 || n_wr !== 4) begin errors++; $display("FAIL rmid_rerun got=%0d/%0d exp=12/4", done_cyc, n_wr); end
    checks++; if ({ev_at, et_at} !== 2'b00) begin errors++; $display("FAIL rmid_rerun_errs got=%b exp=%b", {ev_at, et_at}, 2'b00); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_verify_err();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
